key_debounce: RTL and testbench

- Input-side conditioner for board push-buttons: the receive end of the key/LED pad interface.
- Takes the raw button pad, applies board polarity correction, and synchronises it into clk.
- Debounces the synchronised level, then produces a clean level, one-cycle press/release strobes and a press-toggled flag.
- The toggled flag can directly drive a TBUF OEN or LED enable in top-level examples.

---
 rtl/key_debounce_pkg.sv | 26 ++
 rtl/key_debounce_sync_2ff.sv | 38 +++
 rtl/key_debounce.sv | 107 ++++++++++
 tb/tb_key_debounce.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// key_debounce_pkg
//   Shared types and helpers for the push-button input conditioner.
//   - key_event_e : what an accepted debounce decision means for the strobes
//   - key_event_of: classifies an accepted level change into press/release
//   - DEBOUNCE_CYCLES_MIN/MAX: legal range of the debounce length
// ---------------------------------------------------------------------------
package key_debounce_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_MIN = 2;
  localparam int unsigned DEBOUNCE_CYCLES_MAX = 1 << 24;

  typedef enum logic [1:0] {
    KEY_EV_NONE    = 2'd0,
    KEY_EV_PRESS   = 2'd1,
    KEY_EV_RELEASE = 2'd2
  } key_event_e;

  // Maps a newly accepted level onto the strobe it must produce. Only
  // called when the accepted level differs from the current one, so the
  // new level alone identifies the direction.
  function automatic key_event_e key_event_of(input logic new_level);
    return new_level ? KEY_EV_PRESS : KEY_EV_RELEASE;
  endfunction

endpackage : key_debounce_pkg

// File: rtl/key_debounce_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous bit. The two stages are
//   directly chained so the first flop has a full cycle to resolve
//   metastability. Reused by the pad-input blocks.
//
//   Parameters:
//     RST_VAL - value both stages take while rst is asserted
//   Ports:
//     clk - system clock, rising edge
//     rst - synchronous, active-high reset
//     d   - asynchronous input bit
//     q   - synchronised output (two cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make s1 and q update together at the
    // edge; blocking here would collapse the two stages into one.
    if (rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule : sync_2ff

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Receive-side conditioner for a board push-button. Corrects the pad
//   polarity, synchronises into clk, debounces the level and derives clean
//   press/release strobes plus a press-toggled flag (suitable to drive a
//   TBUF OEN or LED enable directly).
//
//   Parameters:
//     DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a new
//                       level (2 .. 2**24)
//     INV             - 1 when the pad is active-low
//     CNT_W           - counter width, derived from DEBOUNCE_CYCLES
//   Ports:
//     clk         - system clock, rising edge
//     rst         - synchronous, active-high reset
//     key_i       - raw asynchronous button pad
//     key_level   - debounced logical level (1 = pressed)
//     key_press   - one-cycle strobe on an accepted 0->1 of key_level
//     key_release - one-cycle strobe on an accepted 1->0 of key_level
//     key_toggle  - inverts on every key_press
//
//   All outputs are registered; there is no combinational path from key_i.
// ---------------------------------------------------------------------------
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter bit          INV             = 1'b0,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  // Terminal count: the decision is taken on the edge where the counter
  // already holds DEBOUNCE_CYCLES-1, which is the DEBOUNCE_CYCLES-th
  // consecutive edge that saw a differing level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_raw;
  logic             key_sync;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  key_event_e       key_event;

  // Inversion happens before the synchroniser so the sync stages hold the
  // logical value and reset to 0 (idle) regardless of pad polarity.
  assign key_raw = key_i ^ INV;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_raw),
    .q   (key_sync)
  );

  // Debounce decision. Any return to the current level clears the count,
  // so a bounce shorter than DEBOUNCE_CYCLES never reaches CNT_MAX, and
  // the counter is reset on acceptance so it can never wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    cnt_next   = cnt;
    level_next = key_level;
    key_event  = KEY_EV_NONE;

    if (key_sync == key_level) begin
      cnt_next = '0;
    end else if (cnt == CNT_MAX) begin
      cnt_next   = '0;
      level_next = key_sync;
      key_event  = key_event_of(key_sync);
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Strobes register on the same edge as the new level, so each is high
  // exactly during the first cycle of that level; at most one event is
  // decoded per edge, so they are never high together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_toggle  <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      key_level   <= level_next;
      key_press   <= (key_event == KEY_EV_PRESS);
      key_release <= (key_event == KEY_EV_RELEASE);
      if (key_event == KEY_EV_PRESS) begin
        key_toggle <= ~key_toggle;
      end
    end
  end

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
//   Two instances share clk/rst: u_dut_a (INV=0) and u_dut_b (INV=1), both
//   with DEBOUNCE_CYCLES=4. Inputs are driven just after a falling edge; a
//   change driven while cyc==c is captured at rising edge c+1 and must show
//   as a strobe at edge c+6. Each expected strobe (edge number, direction,
//   toggle value) is queued when the stimulus is driven and popped when the
//   DUT strobes. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_key_debounce;

  localparam int unsigned N       = 4;
  localparam int          LATENCY = N + 2;

  typedef struct {
    int   cyc;
    logic press;
    logic toggle;
  } exp_ev_t;

  logic clk = 1'b0;
  logic rst;
  logic key_a;
  logic key_b;
  logic a_level, a_press, a_release, a_toggle;
  logic b_level, b_press, b_release, b_toggle;

  int   cyc   = 0;
  logic rst_q = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  exp_ev_t q_a[$];
  exp_ev_t q_b[$];
  logic    exp_tog_a = 1'b0;
  logic    exp_tog_b = 1'b0;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES (N),
    .INV             (1'b0)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .key_i       (key_a),
    .key_level   (a_level),
    .key_press   (a_press),
    .key_release (a_release),
    .key_toggle  (a_toggle)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (N),
    .INV             (1'b1)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .key_i       (key_b),
    .key_level   (b_level),
    .key_press   (b_press),
    .key_release (b_release),
    .key_toggle  (b_toggle)
  );

  // Edge counter and the reset value each edge actually sampled.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_a(input logic press);
    if (press) exp_tog_a = ~exp_tog_a;
    q_a.push_back('{cyc: cyc + LATENCY, press: press, toggle: exp_tog_a});
  endtask

  task automatic expect_b(input logic press);
    if (press) exp_tog_b = ~exp_tog_b;
    q_b.push_back('{cyc: cyc + LATENCY, press: press, toggle: exp_tog_b});
  endtask

  // Scoreboard for instance A.
  always @(negedge clk) begin : mon_a
    exp_ev_t e;
    if (rst_q) begin
      check("a_reset_outputs", {a_level, a_press, a_release, a_toggle}, 4'b0000);
    end else if (a_press || a_release) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_strobe", {a_press, a_release}, 2'b00);
      end else begin
        e = q_a.pop_front();
        check("a_strobe_edge",   cyc, e.cyc);
        check("a_strobe_kind",   {a_press, a_release}, {e.press, ~e.press});
        check("a_strobe_level",  a_level, e.press);
        check("a_strobe_toggle", a_toggle, e.toggle);
      end
    end
  end

  // Scoreboard for instance B (inverted pad).
  always @(negedge clk) begin : mon_b
    exp_ev_t e;
    if (rst_q) begin
      check("b_reset_outputs", {b_level, b_press, b_release, b_toggle}, 4'b0000);
    end else if (b_press || b_release) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_strobe", {b_press, b_release}, 2'b00);
      end else begin
        e = q_b.pop_front();
        check("b_strobe_edge",   cyc, e.cyc);
        check("b_strobe_kind",   {b_press, b_release}, {e.press, ~e.press});
        check("b_strobe_level",  b_level, e.press);
        check("b_strobe_toggle", b_toggle, e.toggle);
      end
    end
  end

  initial begin
    // Reset held 3 edges with the key already pressed; B idles high (released).
    rst   = 1'b1;
    key_a = 1'b1;
    key_b = 1'b1;
    step(3);
    rst = 1'b0;
    expect_a(1'b1);
    step(10);
    key_a = 1'b0;
    expect_a(1'b0);
    step(10);

    // Clean press and release.
    key_a = 1'b1;
    expect_a(1'b1);
    step(10);
    key_a = 1'b0;
    expect_a(1'b0);
    step(10);

    // Bounce: 3-cycle pulses are one short of acceptance.
    for (int i = 0; i < 2; i++) begin
      key_a = 1'b1;
      step(3);
      key_a = 1'b0;
      step(3);
    end
    step(10);
    check("a_level_after_bounce", a_level, 1'b0);
    key_a = 1'b1;
    expect_a(1'b1);
    step(10);
    key_a = 1'b0;
    expect_a(1'b0);
    step(10);

    // Toggle sequence from a fresh reset: toggle goes 1,0,1.
    rst = 1'b1;
    exp_tog_a = 1'b0;
    exp_tog_b = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
    for (int i = 0; i < 3; i++) begin
      key_a = 1'b1;
      expect_a(1'b1);
      step(8);
      key_a = 1'b0;
      expect_a(1'b0);
      step(8);
    end
    check("a_toggle_after_seq", a_toggle, 1'b1);

    // Reset mid-count: the counter holds 2 when rst is asserted.
    key_a = 1'b1;
    step(4);
    rst = 1'b1;
    exp_tog_a = 1'b0;
    exp_tog_b = 1'b0;
    step(1);
    rst = 1'b0;
    expect_a(1'b1);
    step(12);
    key_a = 1'b0;
    expect_a(1'b0);
    step(10);

    // Inverted pad: driving 0 is a press, returning to 1 a release, and a
    // long idle at 1 must stay silent.
    key_b = 1'b0;
    expect_b(1'b1);
    step(10);
    key_b = 1'b1;
    expect_b(1'b0);
    step(40);

    check("a_pending_events", q_a.size(), 0);
    check("b_pending_events", q_b.size(), 0);
    check("a_final_level",    a_level, 1'b0);
    check("b_final_level",    b_level, 1'b0);
    check("b_final_toggle",   b_toggle, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_key_debounce
